// File: rtl/uart_loader.sv
// Framed program loader fed by the UART receiver: SYNC, ADDR_HI, ADDR_LO, LEN, DATA x N, CHK.
// Payload bytes are written to CPU memory while the CPU is held; the frame ends with a done or error pulse.
module uart_loader #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_CLKS = 1000000
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic        o_Mem_We,
    output logic [15:0] o_Mem_Addr,
    output logic [7:0]  o_Mem_Data,
    output logic        o_Cpu_Hold,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Error
);

    typedef enum logic [2:0] {
        IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_DATA, S_CHK
    } state_t;

    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CLKS - 1);

    state_t      state, state_nx;
    logic [15:0] addr_q, addr_nx;
    logic [8:0]  cnt_q, cnt_nx;
    logic [7:0]  sum_q, sum_nx, sum_add;
    logic [23:0] to_q, to_nx;
    logic        we_nx, done_nx, err_nx;
    logic [15:0] maddr_nx;
    logic [7:0]  mdata_nx;

    assign sum_add = sum_q + i_Rx_Byte;

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            to_q       <= '0;
            o_Mem_We   <= 1'b0;
            o_Mem_Addr <= '0;
            o_Mem_Data <= '0;
            o_Cpu_Hold <= 1'b0;
            o_Busy     <= 1'b0;
            o_Done     <= 1'b0;
            o_Error    <= 1'b0;
        end else begin
            state      <= state_nx;
            addr_q     <= addr_nx;
            cnt_q      <= cnt_nx;
            sum_q      <= sum_nx;
            to_q       <= to_nx;
            o_Mem_We   <= we_nx;
            o_Mem_Addr <= maddr_nx;
            o_Mem_Data <= mdata_nx;
            o_Cpu_Hold <= (state_nx != IDLE);
            o_Busy     <= (state_nx != IDLE);
            o_Done     <= done_nx;
            o_Error    <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        cnt_nx   = cnt_q;
        sum_nx   = sum_q;
        to_nx    = (state == IDLE) ? 24'd0 : to_q + 24'd1;
        we_nx    = 1'b0;
        maddr_nx = o_Mem_Addr;
        mdata_nx = o_Mem_Data;
        done_nx  = 1'b0;
        err_nx   = 1'b0;

        // An accepted byte always takes priority over the timeout terminal count
        if (i_Rx_DV) begin
            to_nx = 24'd0;
            case (state)
                IDLE: begin
                    if (i_Rx_Byte == SYNC_BYTE) begin
                        state_nx = S_ADDR_HI;
                        sum_nx   = 8'd0;
                    end
                end
                S_ADDR_HI: begin
                    addr_nx  = {i_Rx_Byte, addr_q[7:0]};
                    sum_nx   = sum_add;
                    state_nx = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    addr_nx  = {addr_q[15:8], i_Rx_Byte};
                    sum_nx   = sum_add;
                    state_nx = S_LEN;
                end
                S_LEN: begin
                    cnt_nx   = (i_Rx_Byte == 8'd0) ? 9'd256 : {1'b0, i_Rx_Byte};
                    sum_nx   = sum_add;
                    state_nx = S_DATA;
                end
                S_DATA: begin
                    we_nx    = 1'b1;
                    maddr_nx = addr_q;
                    mdata_nx = i_Rx_Byte;
                    addr_nx  = addr_q + 16'd1;
                    cnt_nx   = cnt_q - 9'd1;
                    sum_nx   = sum_add;
                    if (cnt_q == 9'd1) begin
                        state_nx = S_CHK;
                    end
                end
                S_CHK: begin
                    state_nx = IDLE;
                    sum_nx   = sum_add;
                    if (sum_add == 8'd0) begin
                        done_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (state != IDLE && to_q == TO_LAST) begin
            state_nx = IDLE;
            to_nx    = 24'd0;
            err_nx   = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: good/bad frames, address wrap, LEN=0, noise, timeout and mid-frame reset.
module tb_uart_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    uart_loader #(
        .SYNC_BYTE    (8'hA5),
        .TIMEOUT_CLKS (100)
    ) dut (
        .i_Clock    (clk),
        .i_Reset_n  (rst_n),
        .i_Rx_DV    (rx_dv),
        .i_Rx_Byte  (rx_byte),
        .o_Mem_We   (mem_we),
        .o_Mem_Addr (mem_addr),
        .o_Mem_Data (mem_data),
        .o_Cpu_Hold (cpu_hold),
        .o_Busy     (busy),
        .o_Done     (done),
        .o_Error    (error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write/pulse log captured away from the active edge
    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    int          done_n;
    int          err_n;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_data);
            end
            if (done)  done_n++;
            if (error) err_n++;
        end
    end

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_n = 0;
        err_n  = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the byte was sampled
    task automatic send_byte(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] frm[$];

    task automatic send_frm();
        foreach (frm[i]) send_byte(frm[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bad;
        done_n  = 0;
        err_n   = 0;
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_we",   mem_we,   0);
        check_val("rst_addr", mem_addr, 0);
        check_val("rst_data", mem_data, 0);
        check_val("rst_hold", cpu_hold, 0);
        check_val("rst_busy", busy,     0);
        check_val("rst_done", done,     0);
        check_val("rst_err",  error,    0);
        rst_n = 1'b1;
        idle(2);

        // Noise in IDLE
        clear_log();
        send_byte(8'h00);
        check_val("noise00_busy", busy, 0);
        send_byte(8'hFF);
        check_val("noiseFF_busy", busy, 0);
        send_byte(8'h5A);
        check_val("noise5A_busy", busy, 0);
        idle(2);
        check_val("noise_writes", wa.size(), 0);
        check_val("noise_err", err_n, 0);

        // Good frame with cycle-accurate checks
        clear_log();
        send_byte(8'hA5);
        check_val("good_busy_rise", busy, 1);
        check_val("good_hold_rise", cpu_hold, 1);
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h3E);
        check_val("good_we0",   mem_we,   1);
        check_val("good_addr0", mem_addr, 16'h0010);
        check_val("good_data0", mem_data, 8'h3E);
        send_byte(8'h07);
        check_val("good_we1",   mem_we,   1);
        check_val("good_addr1", mem_addr, 16'h0011);
        check_val("good_data1", mem_data, 8'h07);
        send_byte(8'hA9);
        check_val("good_we_off",    mem_we,   0);
        check_val("good_done",      done,     1);
        check_val("good_busy_fall", busy,     0);
        check_val("good_hold_fall", cpu_hold, 0);
        idle(1);
        check_val("good_done_1cyc", done, 0);
        idle(2);
        check_val("good_writes", wa.size(), 2);
        check_val("good_done_n", done_n, 1);
        check_val("good_err_n",  err_n,  0);

        // Address wrap
        clear_log();
        frm = '{8'hA5, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h22, 8'hCD};
        send_frm();
        idle(2);
        check_val("wrap_writes", wa.size(), 2);
        if (wa.size() == 2) begin
            check_val("wrap_addr0", wa[0], 16'hFFFF);
            check_val("wrap_data0", wd[0], 8'h11);
            check_val("wrap_addr1", wa[1], 16'h0000);
            check_val("wrap_data1", wd[1], 8'h22);
        end
        check_val("wrap_done_n", done_n, 1);
        check_val("wrap_err_n",  err_n,  0);

        // Bad checksum, immediately followed by a SYNC-valued data byte frame
        clear_log();
        frm = '{8'hA5, 8'h00, 8'h10, 8'h02, 8'h3E, 8'h07, 8'hAA};
        send_frm();
        check_val("bad_err_pulse", error, 1);
        check_val("bad_busy", busy, 0);
        frm = '{8'hA5, 8'h00, 8'h30, 8'h01, 8'hA5, 8'h2A};
        send_frm();
        idle(2);
        check_val("bad_writes", wa.size(), 3);
        check_val("bad_err_n",  err_n,  1);
        check_val("bad_done_n", done_n, 1);
        if (wa.size() == 3) begin
            check_val("sync_data_addr", wa[2], 16'h0030);
            check_val("sync_data_val",  wd[2], 8'hA5);
        end

        // Inter-byte timeout after two bytes
        clear_log();
        send_byte(8'hA5);
        send_byte(8'h00);
        k = 0;
        while (!error && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_val("to_latency", k, 100);
        check_val("to_busy", busy, 0);
        check_val("to_hold", cpu_hold, 0);
        idle(1);
        check_val("to_err_1cyc", error, 0);
        idle(2);
        check_val("to_err_n", err_n, 1);

        // Byte arriving on the terminal-count cycle wins
        clear_log();
        send_byte(8'hA5);
        idle(99);
        frm = '{8'h00, 8'h10, 8'h02, 8'h3E, 8'h07, 8'hA9};
        send_frm();
        idle(2);
        check_val("tc_race_err_n",  err_n,  0);
        check_val("tc_race_done_n", done_n, 1);
        check_val("tc_race_writes", wa.size(), 2);

        // LEN=0 means 256 bytes
        clear_log();
        frm = '{8'hA5, 8'h20, 8'h00, 8'h00};
        send_frm();
        for (int i = 0; i < 256; i++) send_byte(8'h01);
        send_byte(8'hE0);
        idle(2);
        check_val("len0_writes", wa.size(), 256);
        if (wa.size() == 256) begin
            check_val("len0_first", wa[0],   16'h2000);
            check_val("len0_last",  wa[255], 16'h20FF);
            bad = 0;
            for (int i = 0; i < 256; i++) begin
                if (wa[i] !== 16'h2000 + 16'(i) || wd[i] !== 8'h01) bad++;
            end
            check_val("len0_contents", bad, 0);
        end
        check_val("len0_done_n", done_n, 1);
        check_val("len0_err_n",  err_n,  0);

        // Reset in the middle of an LEN=5 frame
        clear_log();
        frm = '{8'hA5, 8'h00, 8'h40, 8'h05, 8'h11, 8'h22, 8'h33};
        send_frm();
        check_val("mid_we_before", mem_we, 1);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_we",   mem_we,   0);
        check_val("mid_rst_addr", mem_addr, 0);
        check_val("mid_rst_data", mem_data, 0);
        check_val("mid_rst_hold", cpu_hold, 0);
        check_val("mid_rst_busy", busy,     0);
        check_val("mid_rst_done", done,     0);
        check_val("mid_rst_err",  error,    0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        clear_log();
        frm = '{8'hA5, 8'h00, 8'h10, 8'h02, 8'h3E, 8'h07, 8'hA9};
        send_frm();
        idle(2);
        check_val("post_rst_writes", wa.size(), 2);
        if (wa.size() == 2) begin
            check_val("post_rst_addr0", wa[0], 16'h0010);
            check_val("post_rst_data1", wd[1], 8'h07);
        end
        check_val("post_rst_done_n", done_n, 1);
        check_val("post_rst_err_n",  err_n,  0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
